// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, flag indices and op classes for the alu
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    localparam int F_C   = 0;
    localparam int F_Z   = 1;
    localparam int F_N   = 2;
    localparam int F_V   = 3;
    localparam int F_P   = 4;
    localparam int F_EQ  = 5;
    localparam int F_LTU = 6;
    localparam int F_LTS = 7;

    // Flag logic only needs to know how the result was produced, not the exact opcode.
    typedef enum logic [1:0] {
        CLS_ADD   = 2'd0,
        CLS_SUB   = 2'd1,
        CLS_LOGIC = 2'd2
    } op_class_e;

    function automatic op_class_e op_class(input logic [1:0] sel);
        case (sel)
            OP_ADD:  op_class = CLS_ADD;
            OP_SUB:  op_class = CLS_SUB;
            default: op_class = CLS_LOGIC;
        endcase
    endfunction

endpackage

// File: rtl/alu_if.sv
// rtl/alu_if.sv - operand/opcode and result/flag bundle for the alu
interface alu_if;

    logic [7:0] A;
    logic [7:0] B;
    logic       c;
    logic [1:0] sel;
    logic [7:0] O;
    logic [7:0] flag;

    modport master (
        output A, B, c, sel,
        input  O, flag
    );

    modport slave (
        input  A, B, c, sel,
        output O, flag
    );

endinterface

// File: rtl/alu_flags.sv
// rtl/alu_flags.sv - combinational status flag generation from operands and result
module alu_flags
    import alu_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [7:0] result,
    input  logic       carry,
    input  op_class_e  cls,
    output logic [7:0] flags
);

    always_comb begin
        flags = 8'h00;

        flags[F_C] = (cls == CLS_LOGIC) ? 1'b0 : carry;
        flags[F_Z] = (result == 8'h00);
        flags[F_N] = result[7];
        flags[F_P] = ^result;

        // Overflow: result sign disagrees with A when the effective operand signs agree.
        case (cls)
            CLS_ADD: flags[F_V] = (a[7] == b[7]) && (result[7] != a[7]);
            CLS_SUB: flags[F_V] = (a[7] != b[7]) && (result[7] != a[7]);
            default: flags[F_V] = 1'b0;
        endcase

        flags[F_EQ]  = (a == b);
        flags[F_LTU] = (a < b);
        flags[F_LTS] = ($signed(a) < $signed(b));
    end

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - 8-bit registered ALU: add/sub with carry, and, xor, plus status flags
module alu
    import alu_pkg::*;
(
    input  logic clk,
    input  logic rst,
    alu_if.slave bus
);

    logic [8:0] sum9;
    logic [8:0] diff9;
    logic [7:0] o_d;
    logic [7:0] o_q;
    logic       carry_d;
    logic [7:0] flag_d;
    logic [7:0] flag_q;
    op_class_e  cls;

    // Bit 8 of the 9-bit difference goes high exactly when A < B + c.
    assign sum9  = {1'b0, bus.A} + {1'b0, bus.B} + {8'h00, bus.c};
    assign diff9 = {1'b0, bus.A} - {1'b0, bus.B} - {8'h00, bus.c};
    assign cls   = op_class(bus.sel);

    always_comb begin
        o_d     = 8'h00;
        carry_d = 1'b0;
        case (bus.sel)
            OP_ADD: begin
                o_d     = sum9[7:0];
                carry_d = sum9[8];
            end
            OP_SUB: begin
                o_d     = diff9[7:0];
                carry_d = diff9[8];
            end
            OP_AND:  o_d = bus.A & bus.B;
            default: o_d = bus.A ^ bus.B;
        endcase
    end

    alu_flags u_flags (
        .a      (bus.A),
        .b      (bus.B),
        .result (o_d),
        .carry  (carry_d),
        .cls    (cls),
        .flags  (flag_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_q    <= 8'h00;
            flag_q <= 8'h00;
        end else begin
            o_q    <= o_d;
            flag_q <= flag_d;
        end
    end

    assign bus.O    = o_q;
    assign bus.flag = flag_q;

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - self-checking bench: directed corner vectors plus random ops vs arithmetic model
module tb_alu;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    alu_if bus ();

    alu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Reference: whole-number arithmetic on ints, flags from their definitions.
    task automatic model(input logic [7:0] a, input logic [7:0] b, input logic ci,
                         input logic [1:0] sel, output logic [7:0] o, output logic [7:0] f);
        int ua, ub, sa, sb, uc, full, sfull;
        ua = int'(a); ub = int'(b);
        sa = (ua > 127) ? ua - 256 : ua;
        sb = (ub > 127) ? ub - 256 : ub;
        uc = ci ? 1 : 0;
        f  = 8'h00;
        case (sel)
            2'd0: begin
                full  = ua + ub + uc;
                sfull = sa + sb + uc;
                o     = 8'(full % 256);
                f[0]  = (full > 255);
                f[3]  = (sfull > 127) || (sfull < -128);
            end
            2'd1: begin
                full  = ua - ub - uc;
                sfull = sa - sb - uc;
                o     = 8'((full + 512) % 256);
                f[0]  = (full < 0);
                f[3]  = (sfull > 127) || (sfull < -128);
            end
            2'd2: o = a & b;
            default: o = a ^ b;
        endcase
        f[1] = (o == 8'h00);
        f[2] = (int'(o) >= 128);
        f[4] = ($countones(o) % 2) == 1;
        f[5] = (ua == ub);
        f[6] = (ua < ub);
        f[7] = (sa < sb);
    endtask

    task automatic run(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic [1:0] sel);
        logic [7:0] eo, ef;
        @(negedge clk);
        bus.A = a; bus.B = b; bus.c = ci; bus.sel = sel;
        model(a, b, ci, sel, eo, ef);
        @(posedge clk);
        #1;
        chk({tag, ".O"}, bus.O, eo);
        chk({tag, ".flag"}, bus.flag, ef);
    endtask

    initial begin
        bus.A = 8'h00; bus.B = 8'h00; bus.c = 1'b0; bus.sel = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.O", bus.O, 8'h00);
        chk("rst.flag", bus.flag, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        run("add_01_01", 8'h01, 8'h01, 1'b0, 2'b00);
        chk("add_01_01.const", bus.flag, 8'h30);
        run("sub_01_01", 8'h01, 8'h01, 1'b0, 2'b01);
        chk("sub_01_01.const", bus.flag, 8'h22);
        run("and_01_01", 8'h01, 8'h01, 1'b0, 2'b10);
        run("and_ff_ff", 8'hFF, 8'hFF, 1'b0, 2'b10);
        chk("and_ff_ff.const", bus.flag, 8'h24);
        run("and_55_ff", 8'h55, 8'hFF, 1'b0, 2'b10);
        run("and_55_aa", 8'h55, 8'hAA, 1'b0, 2'b10);
        run("add_55_aa", 8'h55, 8'hAA, 1'b0, 2'b00);
        run("sub_55_aa", 8'h55, 8'hAA, 1'b0, 2'b01);
        chk("sub_55_aa.const", bus.flag, 8'h5D);
        run("addc_ff_01", 8'hFF, 8'h01, 1'b1, 2'b00);
        chk("addc_ff_01.const_O", bus.O, 8'h01);
        chk("addc_ff_01.const", bus.flag, 8'h91);
        run("subc_00_00", 8'h00, 8'h00, 1'b1, 2'b01);
        chk("subc_00_00.const_O", bus.O, 8'hFF);
        run("xor_f0_0f", 8'hF0, 8'h0F, 1'b0, 2'b11);
        run("add_7f_01", 8'h7F, 8'h01, 1'b0, 2'b00);
        run("sub_80_01", 8'h80, 8'h01, 1'b0, 2'b01);
        run("sub_80_00c", 8'h80, 8'h00, 1'b1, 2'b01);
        run("add_7f_00c", 8'h7F, 8'h00, 1'b1, 2'b00);

        // Async reset between edges must clear outputs before any clock.
        run("pre_rst", 8'h55, 8'hAA, 1'b0, 2'b01);
        @(negedge clk);
        bus.A = 8'hFF; bus.B = 8'h01; bus.c = 1'b1; bus.sel = 2'b00;
        #2 rst = 1'b1;
        #1;
        chk("async_rst.O", bus.O, 8'h00);
        chk("async_rst.flag", bus.flag, 8'h00);
        @(posedge clk);
        #1;
        chk("rst_hold.O", bus.O, 8'h00);
        chk("rst_hold.flag", bus.flag, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        run("post_rst", 8'hFF, 8'h01, 1'b1, 2'b00);

        for (int i = 0; i < 400; i++) begin
            run($sformatf("rnd%0d", i), 8'($urandom), 8'($urandom),
                1'($urandom), 2'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
